// File: rtl/fifo_deq_serializer.sv
// Pops wide words from a FIFO dequeue port and emits them as narrow beats on a
// valid/ready stream, reloading in the same cycle the last beat is accepted.
module fifo_deq_serializer #(
  parameter int width      = 32,
  parameter int beat_width = 8,
  parameter int msb_first  = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [width-1:0]      FIFO_D,
  input  logic                  FIFO_EMPTY_N,
  output logic                  FIFO_DEQ,
  input  logic                  CLR,
  output logic [beat_width-1:0] BEAT_OUT,
  output logic                  BEAT_VALID,
  input  logic                  BEAT_READY,
  output logic                  BEAT_LAST,
  output logic                  BUSY
);

  localparam int NBEATS = width / beat_width;
  localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                 state_p0, state_nxt;
  logic [width-1:0]       hold_p0;
  logic [IDX_W-1:0]       idx_p0, idx_nxt;
  logic                   vld_p0;
  logic                   accept;
  logic                   done;
  logic                   deq;

  // Slice k of the held word; msb_first walks the slices from the top down.
  function automatic logic [beat_width-1:0] beat_slice(
    input logic [width-1:0] w,
    input logic [IDX_W-1:0] k
  );
    logic [IDX_W-1:0]      sel;
    logic [beat_width-1:0] r;
    sel = (msb_first != 0) ? (LAST_IDX - k) : k;
    r   = '0;
    for (int i = 0; i < NBEATS; i++) begin
      if (sel == IDX_W'(i)) r = w[i*beat_width +: beat_width];
    end
    return r;
  endfunction

  always_comb begin
    vld_p0 = (state_p0 == SHIFT);
    accept = vld_p0 && BEAT_READY;
    done   = accept && (idx_p0 == LAST_IDX);
    deq    = FIFO_EMPTY_N && !RST && !CLR && ((state_p0 == IDLE) || done);
  end

  // Next-state: CLR outranks loading; a load on the final accept keeps SHIFT.
  always_comb begin
    state_nxt = state_p0;
    idx_nxt   = idx_p0;
    if (CLR) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
    end else if (deq) begin
      state_nxt = SHIFT;
      idx_nxt   = '0;
    end else if (done) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
    end else if (accept) begin
      idx_nxt = idx_p0 + IDX_W'(1);
    end
  end

  // ---- stage p0: control registers (reset) and held word (no reset) ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_p0 <= IDLE;
      idx_p0   <= '0;
    end else begin
      state_p0 <= state_nxt;
      idx_p0   <= idx_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (deq) hold_p0 <= FIFO_D;
  end

  always_comb begin
    FIFO_DEQ   = deq;
    BEAT_VALID = vld_p0;
    BUSY       = vld_p0;
    BEAT_LAST  = vld_p0 && (idx_p0 == LAST_IDX);
    BEAT_OUT   = beat_slice(hold_p0, idx_p0);
  end

  always_ff @(posedge CLK) begin
    assert (width % beat_width == 0);
    assert (!(FIFO_DEQ && !FIFO_EMPTY_N));
  end

endmodule

// File: tb/tb_fifo_deq_serializer.sv
// Randomized bench for fifo_deq_serializer: lsb-first and msb-first 32/8
// instances sharing one FIFO, plus an 8/8 single-beat instance on its own FIFO.
module tb_fifo_deq_serializer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CLR = 1'b0;
  logic        BEAT_READY = 1'b0;
  logic [31:0] fifo_d_ab = '0;
  logic        empty_n_ab = 1'b0;
  logic [7:0]  fifo_d_c = '0;
  logic        empty_n_c = 1'b0;

  logic       deq_a, vld_a, last_a, busy_a;
  logic [7:0] out_a;
  logic       deq_b, vld_b, last_b, busy_b;
  logic [7:0] out_b;
  logic       deq_c, vld_c, last_c, busy_c;
  logic [7:0] out_c;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] fa_q[$];
  logic [7:0]  fc_q[$];
  logic [8:0]  ea_q[$];
  logic [8:0]  eb_q[$];
  logic [8:0]  ec_q[$];

  always #5 CLK = ~CLK;

  fifo_deq_serializer #(.width(32), .beat_width(8), .msb_first(0)) u_a (
    .CLK(CLK), .RST(RST), .FIFO_D(fifo_d_ab), .FIFO_EMPTY_N(empty_n_ab),
    .FIFO_DEQ(deq_a), .CLR(CLR), .BEAT_OUT(out_a), .BEAT_VALID(vld_a),
    .BEAT_READY(BEAT_READY), .BEAT_LAST(last_a), .BUSY(busy_a));

  fifo_deq_serializer #(.width(32), .beat_width(8), .msb_first(1)) u_b (
    .CLK(CLK), .RST(RST), .FIFO_D(fifo_d_ab), .FIFO_EMPTY_N(empty_n_ab),
    .FIFO_DEQ(deq_b), .CLR(CLR), .BEAT_OUT(out_b), .BEAT_VALID(vld_b),
    .BEAT_READY(BEAT_READY), .BEAT_LAST(last_b), .BUSY(busy_b));

  fifo_deq_serializer #(.width(8), .beat_width(8), .msb_first(0)) u_c (
    .CLK(CLK), .RST(RST), .FIFO_D(fifo_d_c), .FIFO_EMPTY_N(empty_n_c),
    .FIFO_DEQ(deq_c), .CLR(CLR), .BEAT_OUT(out_c), .BEAT_VALID(vld_c),
    .BEAT_READY(BEAT_READY), .BEAT_LAST(last_c), .BUSY(busy_c));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  // Beat k of a word as {last, data}, ordered by the msb_first rule.
  function automatic logic [8:0] beat_of(input logic [31:0] w, input int k,
                                         input int nb, input bit msb);
    int pos;
    logic [31:0] sh;
    pos = msb ? (nb - 1 - k) : k;
    sh  = w >> (8 * pos);
    return {(k == nb - 1), sh[7:0]};
  endfunction

  task automatic chk_out(input string p, input logic v, input logic l, input logic bz,
                         input logic [7:0] o, input bit has, input logic [8:0] front);
    chk({p, "_valid"}, 32'(v), 32'(has));
    chk({p, "_busy"}, 32'(bz), 32'(has));
    chk({p, "_last"}, 32'(l), 32'(has && front[8]));
    if (has) chk({p, "_beat"}, 32'(o), 32'(front[7:0]));
  endtask

  task automatic cycle(input bit rdy, input bit clr, input bit rst,
                       input bit ga, input bit gc);
    bit acc_a, acc_b, acc_c, ed_a, ed_b, ed_c, pop_ab, pop_c;
    @(negedge CLK);
    chk_out("a", vld_a, last_a, busy_a, out_a, ea_q.size() > 0,
            ea_q.size() > 0 ? ea_q[0] : 9'h0);
    chk_out("b", vld_b, last_b, busy_b, out_b, eb_q.size() > 0,
            eb_q.size() > 0 ? eb_q[0] : 9'h0);
    chk_out("c", vld_c, last_c, busy_c, out_c, ec_q.size() > 0,
            ec_q.size() > 0 ? ec_q[0] : 9'h0);

    BEAT_READY = rdy;
    CLR        = clr;
    RST        = rst;
    empty_n_ab = ga && (fa_q.size() > 0);
    fifo_d_ab  = (fa_q.size() > 0) ? fa_q[0] : $urandom;
    empty_n_c  = gc && (fc_q.size() > 0);
    fifo_d_c   = (fc_q.size() > 0) ? fc_q[0] : 8'($urandom);
    #1;

    acc_a = (ea_q.size() > 0) && rdy;
    acc_b = (eb_q.size() > 0) && rdy;
    acc_c = (ec_q.size() > 0) && rdy;
    ed_a = empty_n_ab && !rst && !clr && (ea_q.size() == 0 || (ea_q.size() == 1 && acc_a));
    ed_b = empty_n_ab && !rst && !clr && (eb_q.size() == 0 || (eb_q.size() == 1 && acc_b));
    ed_c = empty_n_c  && !rst && !clr && (ec_q.size() == 0 || (ec_q.size() == 1 && acc_c));
    chk("a_deq", 32'(deq_a), 32'(ed_a));
    chk("b_deq", 32'(deq_b), 32'(ed_b));
    chk("c_deq", 32'(deq_c), 32'(ed_c));

    if (rst || clr) begin
      ea_q.delete();
      eb_q.delete();
      ec_q.delete();
    end else begin
      if (acc_a) void'(ea_q.pop_front());
      if (acc_b) void'(eb_q.pop_front());
      if (acc_c) void'(ec_q.pop_front());
      if (ed_a) for (int k = 0; k < 4; k++) ea_q.push_back(beat_of(fa_q[0], k, 4, 1'b0));
      if (ed_b) for (int k = 0; k < 4; k++) eb_q.push_back(beat_of(fa_q[0], k, 4, 1'b1));
      if (ed_c) ec_q.push_back(beat_of(32'(fc_q[0]), 0, 1, 1'b0));
    end
    pop_ab = deq_a;
    pop_c  = deq_c;

    @(posedge CLK);
    if (pop_ab && fa_q.size() > 0) void'(fa_q.pop_front());
    if (pop_c && fc_q.size() > 0) void'(fc_q.pop_front());
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    // single word at full rate
    fa_q.push_back(32'hA1B2C3D4);
    fc_q.push_back(8'hA1);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    // back-to-back words, no bubble
    fa_q.push_back(32'h03020100);
    fa_q.push_back(32'h07060504);
    fc_q.push_back(8'h10);
    fc_q.push_back(8'h11);
    for (int i = 0; i < 11; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    // backpressure with READY 1,0,0,1,...
    fa_q.push_back(32'hDEADBEEF);
    fa_q.push_back(32'h0BADF00D);
    fc_q.push_back(8'h5A);
    fc_q.push_back(8'hC3);
    for (int i = 0; i < 24; i++) cycle((i % 3) == 0, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();

    // CLR after two accepted beats
    fa_q.push_back(32'h11223344);
    fa_q.push_back(32'h55667788);
    fc_q.push_back(8'h44);
    fc_q.push_back(8'h88);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();

    // RST mid-word with data waiting in the FIFO
    fa_q.push_back(32'h99AABBCC);
    fa_q.push_back(32'hDDEEFF00);
    fa_q.push_back(32'h12345678);
    fc_q.push_back(8'h77);
    fc_q.push_back(8'h66);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (fa_q.size() < 3) fa_q.push_back($urandom);
      if (fc_q.size() < 3) fc_q.push_back(8'($urandom));
      cycle($urandom_range(99) < 70, $urandom_range(99) < 3, $urandom_range(199) < 2,
            $urandom_range(99) < 80, $urandom_range(99) < 80);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
